// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One buffered fetch result: the word and the PC it was fetched from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: synchronous FIFO of fetch_entry_t between imem responses and decode.
// Latency: a pushed entry shows at head_o/count_o the cycle after the push.
// Backpressure: none internally; the caller's credit rule keeps pushes off a full queue.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  fetch_entry_t           push_dat_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [$clog2(DEPTH):0] count_o,
   output fetch_entry_t           head_o
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t    mem_q [DEPTH];
   fetch_entry_t    mem_d [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            do_pop;

   // Next-state for storage, pointers and occupancy; flush empties the queue outright.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop_i && (count_q != '0);
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
      end
   end

   // State registers; entry storage carries no reset since count gates its visibility.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests, queues responses for decode.
// Latency: redirect at t -> request at t+1 -> response at t+2 -> ValidF with target at t+3.
// Backpressure: en_i low stalls the head; issue stops once queue + in-flight reach FQ_DEPTH.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
   parameter int          FQ_DEPTH        = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        en_i,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic [31:0] InstrF,
   output logic        ValidF
);

   localparam int              CW         = $clog2(FQ_DEPTH) + 1;
   localparam int              OW         = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [31:0]     FQ_DEPTH_W = 32'(FQ_DEPTH);
   localparam logic [OW-1:0]   MAX_OUT_W  = OW'(MAX_OUTSTANDING);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [OW-1:0] outstanding_q, outstanding_d;
   logic [OW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] fq_count;
   fetch_entry_t  fq_head;
   fetch_entry_t  push_dat;
   logic          issue, push, pop, valid;
   logic [1:0]    unused_redirect_lsb;

   assign unused_redirect_lsb = redirect_pc_i[1:0];
   assign imem_addr_o         = fetch_pc_q;

   // Request only when every in-flight word plus the buffered ones is guaranteed a queue slot.
   always_comb begin
      imem_req_o = !rst && !redirect_i && (outstanding_q < MAX_OUT_W)
                   && ((32'(fq_count) + 32'(outstanding_q)) < FQ_DEPTH_W);
   end

   // PC/counter next-state; a redirect overrides push, pop and issue in the same cycle.
   always_comb begin
      issue          = imem_req_o && imem_gnt_i;
      valid          = (fq_count != '0);
      fetch_pc_d     = fetch_pc_q;
      resp_pc_d      = resp_pc_q;
      drop_cnt_d     = drop_cnt_q;
      outstanding_d  = outstanding_q + OW'(issue) - OW'(imem_rvalid_i);
      push           = 1'b0;
      pop            = 1'b0;
      push_dat.pc    = resp_pc_q;
      push_dat.instr = imem_rdata_i;
      if (redirect_i) begin
         fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
         resp_pc_d  = {redirect_pc_i[31:2], 2'b00};
         // A response arriving this very cycle is already discarded, so it needs no drop credit.
         drop_cnt_d = outstanding_q - OW'(imem_rvalid_i);
      end else begin
         pop = valid && en_i;
         if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (imem_rvalid_i) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - OW'(1);
            end else begin
               push      = 1'b1;
               resp_pc_d = resp_pc_q + 32'd4;
            end
         end
      end
   end

   // Fetch-side state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_fetch_queue (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .flush_i    (redirect_i),
      .count_o    (fq_count),
      .head_o     (fq_head)
   );

   // Decode-facing view of the queue head; an empty queue presents a NOP at PC 0.
   always_comb begin
      ValidF   = valid;
      PCF      = valid ? fq_head.pc : 32'h0000_0000;
      InstrF   = valid ? fq_head.instr : NOP_INSTR;
      PCPlus4F = PCF + 32'd4;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with a behavioural in-order imem.
// Latency: memory answers one cycle after grant, or 1-6 cycles in random mode.
// Backpressure: decode enable and grant are driven per step.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        en_i = 1'b1;
   logic [31:0] PCF, PCPlus4F, InstrF;
   logic        ValidF;

   int          n_assert = 0;
   int          n_fail   = 0;

   logic [31:0] pend_addr [$];
   int unsigned pend_due [$];
   int unsigned cyc = 0;
   bit          rand_mode = 1'b0;
   bit          hold_resp = 1'b0;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .en_i          (en_i),
      .PCF           (PCF),
      .PCPlus4F      (PCPlus4F),
      .InstrF        (InstrF),
      .ValidF        (ValidF)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd7) ^ 32'hC0DE_0001;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs 1 time unit after the edge, leave 1 more for settling before checks.
   task automatic cycle(input logic r, input logic en, input logic redir, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      rst           = r;
      en_i          = en;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      #1;
   endtask

   // In-order instruction memory: records grants at negedge, answers after the chosen latency.
   initial begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      forever begin
         @(negedge clk);
         if (imem_rvalid_i && pend_addr.size() != 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
         if (imem_req_o && imem_gnt_i) begin
            pend_addr.push_back(imem_addr_o);
            pend_due.push_back(cyc + 32'd1 + (rand_mode ? $urandom_range(5, 0) : 32'd0));
         end
         if (rst) begin
            pend_addr.delete();
            pend_due.delete();
         end
         @(posedge clk);
         #1;
         cyc++;
         imem_gnt_i = rand_mode ? ($urandom_range(3, 0) != 0) : 1'b1;
         if (!hold_resp && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_addr[0]);
         end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] base_pc;
      logic [31:0] exp_pc;
      int          consumed;

      // ---- 1: reset state, then streaming fetch with 1-cycle memory ----
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("rst_req", imem_req_o, 32'd0);
      check("rst_validf", ValidF, 32'd0);
      check("rst_instrf", InstrF, NOP_INSTR);
      check("rst_pcf", PCF, 32'h0);
      check("rst_pcplus4f", PCPlus4F, 32'h4);

      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t1_req_c0", imem_req_o, 32'd1);
      check("t1_addr_c0", imem_addr_o, 32'h0);
      check("t1_valid_c0", ValidF, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t1_addr_c1", imem_addr_o, 32'h4);
      check("t1_valid_c1_nobypass", ValidF, 32'd0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 32'h0);
         check("t1_validf", ValidF, 32'd1);
         check("t1_pcf", PCF, 32'(4 * i));
         check("t1_instrf", InstrF, mem_word(32'(4 * i)));
         check("t1_pcplus4f", PCPlus4F, 32'(4 * i + 4));
      end

      // ---- 2: decode stall fills the queue, then drains without loss ----
      base_pc = 32'd24;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 32'h0);
         check("t2_frozen_pcf", PCF, base_pc);
         check("t2_frozen_instrf", InstrF, mem_word(base_pc));
         if (i >= 2) check("t2_req_stalled", imem_req_o, 32'd0);
      end
      check("t2_queue_full", 32'(dut.fq_count), 32'd4);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 32'h0);
         check("t2_drain_pcf", PCF, base_pc + 32'(4 * i));
         check("t2_drain_valid", ValidF, 32'd1);
         if (i == 0) check("t2_req_rel0", imem_req_o, 32'd0);
         if (i == 1) check("t2_addr_rel1", imem_addr_o, base_pc + 32'd16);
      end

      // ---- 3: redirect with two responses in flight ----
      hold_resp = 1'b1;
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t3_addr_c0", imem_addr_o, 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t3_addr_c1", imem_addr_o, 32'h4);
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100);
      check("t3_two_outstanding", 32'(pend_addr.size()), 32'd2);
      check("t3_req_redirect", imem_req_o, 32'd0);
      hold_resp = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t3_req_full_c3", imem_req_o, 32'd0);
      check("t3_valid_c3", ValidF, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t3_req_c4", imem_req_o, 32'd1);
      check("t3_addr_c4", imem_addr_o, 32'h0000_0100);
      check("t3_valid_c4", ValidF, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t3_valid_c5", ValidF, 32'd0);
      check("t3_addr_c5", imem_addr_o, 32'h0000_0104);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t3_valid_c6", ValidF, 32'd1);
      check("t3_pcf_c6", PCF, 32'h0000_0100);
      check("t3_instrf_c6", InstrF, mem_word(32'h0000_0100));
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t3_pcf_c7", PCF, 32'h0000_0104);
      check("t3_instrf_c7", InstrF, mem_word(32'h0000_0104));

      // ---- 4: unaligned redirect coincident with response and pop ----
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t4_pcf_c2", PCF, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_0203);
      check("t4_pcf_c3", PCF, 32'h4);
      check("t4_rvalid_c3", imem_rvalid_i, 32'd1);
      check("t4_req_redirect", imem_req_o, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t4_valid_flushed", ValidF, 32'd0);
      check("t4_instrf_nop", InstrF, NOP_INSTR);
      check("t4_addr_c4", imem_addr_o, 32'h0000_0200);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t4_valid_c5", ValidF, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t4_valid_c6", ValidF, 32'd1);
      check("t4_pcf_c6", PCF, 32'h0000_0200);
      check("t4_instrf_c6", InstrF, mem_word(32'h0000_0200));
      check("t4_pcplus4f_c6", PCPlus4F, 32'h0000_0204);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t4_pcf_c7", PCF, 32'h0000_0204);

      // ---- 6: fetch PC and PCPlus4F wrap at 2^32 ----
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      check("t6_req_redirect", imem_req_o, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t6_addr_top", imem_addr_o, 32'hFFFF_FFFC);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t6_addr_wrap", imem_addr_o, 32'h0000_0000);
      check("t6_req_wrap", imem_req_o, 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t6_pcf_top", PCF, 32'hFFFF_FFFC);
      check("t6_pcplus4f_wrap", PCPlus4F, 32'h0000_0000);
      check("t6_instrf_top", InstrF, mem_word(32'hFFFF_FFFC));
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t6_pcf_zero", PCF, 32'h0000_0000);
      check("t6_pcplus4f_zero", PCPlus4F, 32'h0000_0004);
      check("t6_instrf_zero", InstrF, mem_word(32'h0000_0000));

      // ---- 5: random grant/latency/enable/redirect against a PC-sequence scoreboard ----
      rand_mode = 1'b1;
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      exp_pc   = DEFAULT_RESET_PC;
      consumed = 0;
      for (int k = 0; k < 600; k++) begin
         logic        r_en;
         logic        r_redir;
         logic [31:0] r_tgt;
         r_en    = ($urandom_range(9, 0) < 7);
         r_redir = ($urandom_range(24, 0) == 0);
         r_tgt   = $urandom();
         cycle(1'b0, r_en, r_redir, r_tgt);
         check("t5_outstanding_le2", 32'(pend_addr.size() <= 2), 32'd1);
         check("t5_count_le4", 32'(dut.fq_count <= 3'd4), 32'd1);
         if (r_redir) begin
            exp_pc = {r_tgt[31:2], 2'b00};
         end else if (ValidF && r_en) begin
            check("t5_pcf_seq", PCF, exp_pc);
            check("t5_instrf_seq", InstrF, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
      end
      check("t5_progress", 32'(consumed >= 50), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
